pmu_pwr_seq_arbiter: RTL

PMU_PWR_SEQ_ARBITER -- requirements
Module: pmu_pwr_seq_arbiter

---
 rtl/pmu_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/pmu_pwr_seq_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pmu_pkg.sv
// Shared definitions for the PMU power sequencer.
// Holds the sequencer FSM state encoding, the default settle/timeout
// constants software is expected to program, and a helper that turns a
// programmed settle value into the number of cycles actually spent settling.
package pmu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_SETTLE    = 2'd3
  } pwr_seq_state_e;

  localparam logic [7:0]  DEFAULT_SETTLE_CYCLES  = 8'd4;
  localparam logic [15:0] DEFAULT_TIMEOUT_CYCLES = 16'd1000;

  // A programmed gap of zero still costs one SETTLE cycle so the ack pulse
  // always has a cycle of its own.
  function automatic logic [7:0] settle_len(input logic [7:0] cycles);
    return (cycles == 8'd0) ? 8'd1 : cycles;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority selector for the power-domain requesters.
// Ports:
//   req_i        - per-domain request vector
//   last_grant_i - index granted most recently; search starts one above it
//   grant_o      - index of the winning requester (valid only with valid_o)
//   valid_o      - at least one request is pending
// Purely combinational; the caller registers the result.
module rr_arbiter #(
  parameter int NUM_DOM = 4,
  localparam int SEL_W = $clog2(NUM_DOM)
) (
  input  logic [NUM_DOM-1:0] req_i,
  input  logic [SEL_W-1:0]   last_grant_i,
  output logic [SEL_W-1:0]   grant_o,
  output logic               valid_o
);

  // Walk the domains starting just after the last winner and wrapping
  // around; the first pending request found wins. The last winner itself is
  // visited last, which is what gives every other requester a fair turn.
  always_comb begin
    int idx;
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_DOM; k++) begin
      idx = (int'(last_grant_i) + k) % NUM_DOM;
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        grant_o = idx[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pmu_pwr_seq_arbiter.sv
// Power-domain sequencer: arbitrates power up/down requests from NUM_DOM
// domains onto one shared power-switch chain, one transition at a time,
// with a programmable inrush settle gap and a done timeout.
// Ports:
//   clk_i, rst_i         - clock, asynchronous active-high reset
//   req_i, req_on_i      - per-domain level request and its target state
//   ack_o                - per-domain one-cycle completion pulse
//   pwr_valid_o          - one-cycle command strobe to the switch chain
//   dom_sel_o, pwr_cmd_o - domain and target state of the command in flight
//   pwr_done_i           - switch-chain completion (level or pulse)
//   settle_cycles_i      - settle gap after each transition (0 acts as 1)
//   timeout_cycles_i     - done timeout in cycles, 0 disables it
//   err_clr_i, err_o     - clear / sticky timeout flag
//   err_dom_o            - domain whose transition timed out
//   dom_state_o          - current power state per domain (1 = on)
//   busy_o               - a transition is in progress
module pmu_pwr_seq_arbiter
  import pmu_pkg::*;
#(
  parameter int                 NUM_DOM     = 4,
  parameter logic [NUM_DOM-1:0] RESET_STATE = '0,
  localparam int                SEL_W       = $clog2(NUM_DOM)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_DOM-1:0] req_i,
  input  logic [NUM_DOM-1:0] req_on_i,
  output logic [NUM_DOM-1:0] ack_o,
  output logic               pwr_valid_o,
  output logic [SEL_W-1:0]   dom_sel_o,
  output logic               pwr_cmd_o,
  input  logic               pwr_done_i,
  input  logic [7:0]         settle_cycles_i,
  input  logic [15:0]        timeout_cycles_i,
  input  logic               err_clr_i,
  output logic               err_o,
  output logic [SEL_W-1:0]   err_dom_o,
  output logic [NUM_DOM-1:0] dom_state_o,
  output logic               busy_o
);

  pwr_seq_state_e     state;
  logic [SEL_W-1:0]   last_grant;
  logic [SEL_W-1:0]   arb_grant;
  logic               arb_valid;
  logic [15:0]        wait_cnt;
  logic [15:0]        wait_cnt_nxt;
  logic [7:0]         settle_cnt;
  logic [NUM_DOM-1:0] sel_onehot;
  logic               timeout_hit;

  rr_arbiter #(.NUM_DOM(NUM_DOM)) u_rr_arbiter (
    .req_i        (req_i),
    .last_grant_i (last_grant),
    .grant_o      (arb_grant),
    .valid_o      (arb_valid)
  );

  // dom_sel_o doubles as the registered grant; it holds from ISSUE through
  // SETTLE, so the ack pulse and the error record are derived from it.
  assign sel_onehot   = {{(NUM_DOM-1){1'b0}}, 1'b1} << dom_sel_o;

  // wait_cnt_nxt is the number of WAIT_DONE cycles completed at this edge;
  // the timeout fires when it reaches the programmed value.
  assign wait_cnt_nxt = wait_cnt + 16'd1;
  assign timeout_hit  = (timeout_cycles_i != 16'd0) && (wait_cnt_nxt == timeout_cycles_i);

  // Sequencer FSM with all outputs registered. ack_o and pwr_valid_o default
  // low every cycle so they can only ever be single-cycle pulses. An error
  // clear is applied first so a timeout on the same edge overrides it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      ack_o       <= '0;
      pwr_valid_o <= 1'b0;
      dom_sel_o   <= '0;
      pwr_cmd_o   <= 1'b0;
      err_o       <= 1'b0;
      err_dom_o   <= '0;
      busy_o      <= 1'b0;
      dom_state_o <= RESET_STATE;
      last_grant  <= SEL_W'(NUM_DOM - 1);
      wait_cnt    <= '0;
      settle_cnt  <= '0;
    end else begin
      ack_o       <= '0;
      pwr_valid_o <= 1'b0;
      if (err_clr_i) begin
        err_o <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            dom_sel_o  <= arb_grant;
            last_grant <= arb_grant;
            pwr_cmd_o  <= req_on_i[arb_grant];
            busy_o     <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (pwr_cmd_o == dom_state_o[dom_sel_o]) begin
            ack_o      <= sel_onehot;
            settle_cnt <= settle_len(settle_cycles_i);
            state      <= ST_SETTLE;
          end else begin
            pwr_valid_o <= 1'b1;
            wait_cnt    <= '0;
            state       <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (pwr_done_i) begin
            dom_state_o[dom_sel_o] <= pwr_cmd_o;
            ack_o                  <= sel_onehot;
            settle_cnt             <= settle_len(settle_cycles_i);
            state                  <= ST_SETTLE;
          end else if (timeout_hit) begin
            err_o      <= 1'b1;
            err_dom_o  <= dom_sel_o;
            ack_o      <= sel_onehot;
            settle_cnt <= settle_len(settle_cycles_i);
            state      <= ST_SETTLE;
          end else begin
            wait_cnt <= wait_cnt_nxt;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt <= 8'd1) begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
